host_cmd_sequencer: RTL and testbench
=====================================

// Module: host_cmd_sequencer
// PURPOSE
//  Upstream command stage for the ISA bus-cycle state machine. It collects a byte-serial host
//  command (cmd, addr lo, addr hi, [data]) and presents address, write data and the control
//  byte. It holds control until the bus engine's control_reset pulse, then returns read data.
// PARAMETERS
//  ADDR_W   16   bus address width; legal range 9..16; the hi byte fills bits [ADDR_W-1:8], excess bits dropped
//  TIMEOUT  255  cycles in S_WAIT without control_reset before abort; must be >= 1
// PORTS
//  clk           in   1       system clock, rising edge
//  reset         in   1       async, active-low; clears all state
//  host_data     in   8       host byte
//  host_wr       in   1       1-cycle strobe: accept host_data (already synchronous to clk)
//  host_rd       in   1       1-cycle strobe: host has consumed host_rdata
//  host_clr      in   1       sync abort of a partially received command; also clears host_err
//  host_busy     out  1       byte not accepted this cycle
//  host_rdata    out  8       captured read data
//  host_rvalid   out  1       host_rdata holds unconsumed read result
//  host_err      out  1       sticky error flag
//  control_out   out  8       to bus engine control input: bit0=read req, bit1=write req, [7:2]=0
//  bus_addr      out  ADDR_W  ISA I/O address, stable while control_out!=0
//  bus_wdata     out  8       ISA write data, stable while control_out!=0
//  bus_rdata     in   8       ISA data bus as seen by this block
//  data_read     in   1       active-low, from bus engine: capture bus_rdata
//  control_reset in   1       active-low, from bus engine: bus cycle complete
// BEHAVIOUR
//  Reset: state=S_CMD; all outputs 0 (host_busy 0); timer 0. Async assert takes effect immediately, including mid-cycle.
//  FSM: S_CMD -> S_ADDR_LO -> S_ADDR_HI -> (write) S_DATA -> S_WAIT; (read) S_ADDR_HI -> S_WAIT.
//   The FSM advances one state per accepted host_wr. No other state change happens, except via host_clr/timeout/control_reset.
//  S_CMD: 0x01=read, 0x02=write. Any other byte sets host_err; the FSM stays in S_CMD.
//  Last byte accepted (addr hi for read, data for write): on that edge control_out<=cmd and state<=S_WAIT.
//   control_out is therefore valid 1 cycle after the final host_wr.
//  S_WAIT: control_out, bus_addr and bus_wdata are held; the timer increments each cycle.
//   On a sampled control_reset==0: control_out<=0, timer<=0, state<=S_CMD. If cmd was read, host_rvalid<=1.
//   This clear lands on the same edge the bus engine returns to idle, so the engine never sees a stale request.
//   If the timer reaches TIMEOUT: control_out<=0, host_err<=1, state<=S_CMD; host_rvalid is not set.
//  Read capture: data_read==0 sampled in S_WAIT with cmd=read -> host_rdata<=bus_rdata (last sample wins).
//   data_read is ignored for write commands and outside S_WAIT.
//  host_busy = (state==S_WAIT) | (state==S_CMD & host_rvalid). The host must drain the read before issuing a new command.
//  host_wr while host_busy: the byte is dropped and host_err<=1.
//  host_rd: clears host_rvalid; it has no effect if host_rvalid==0. host_rdata keeps its value.
//  host_clr: in S_ADDR_LO/S_ADDR_HI/S_DATA returns to S_CMD; bus_addr/bus_wdata keep their last value.
//   It always clears host_err. It is ignored for FSM purposes in S_WAIT (the bus cycle must finish).
//   host_clr with host_wr in the same cycle: clr wins and the byte is dropped without error.
//  control_reset==0 outside S_WAIT is ignored.
//  bus_addr/bus_wdata: registered as each byte is accepted; they change only in S_ADDR_LO/S_ADDR_HI/S_DATA.
// STRUCTURE
//  Shared package/header: command encodings CMD_READ=8'h01, CMD_WRITE=8'h02, control bit indices,
//   and FSM state localparams (3-bit).
//  One natural sub-module: cmd_timeout_timer (clear/enable/expire, TIMEOUT param). Everything else is flat.
// TESTING
//  1 Write: host_wr 02,20,02,5A -> next cycle bus_addr=0x0220, bus_wdata=0x5A, control_out=0x02, busy=1.
//    Then control_reset low 1 cycle -> control_out=0x00 on the same edge, busy=0.
//  2 Read: 01,2A,02; bus_rdata=C3 with data_read low 1 cycle, then control_reset low -> rvalid=1, rdata=C3, busy=1.
//    Then host_wr 01 -> dropped, err=1. Then host_rd -> rvalid=0, busy=0.
//  3 Illegal cmd 03 -> err=1, control_out stays 0, state S_CMD. Then host_clr -> err=0; a subsequent 02,... write completes normally.
//  4 TIMEOUT=8, write issued, control_reset held high -> control_out=0 and err=1 exactly 8 cycles into S_WAIT; busy=0.
//  5 host_clr after addr lo -> back in S_CMD and the next byte is taken as a command. host_clr in S_WAIT -> no effect.
//    Async reset asserted in S_WAIT -> all outputs 0 immediately.
//  6 Write with spurious data_read low -> rdata unchanged, rvalid stays 0 after control_reset.

Source files
------------

// File: rtl/host_cmd_sequencer_pkg.sv
// Shared encodings for the host command sequencer: command bytes, control bit positions, FSM states.
package host_cmd_sequencer_pkg;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam int CTRL_RD_BIT = 0;
  localparam int CTRL_WR_BIT = 1;

  typedef enum logic [2:0] {
    S_CMD     = 3'd0,
    S_ADDR_LO = 3'd1,
    S_ADDR_HI = 3'd2,
    S_DATA    = 3'd3,
    S_WAIT    = 3'd4
  } state_t;

endpackage

// File: rtl/cmd_timeout_timer.sv
// Cycle counter for the bus-wait watchdog; expire is combinational on the TIMEOUT-th enabled cycle.
// Clear has priority and the counter also self-clears on expiry.
module cmd_timeout_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  assign expire = enable && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/host_cmd_sequencer.sv
// Collects cmd/addr/data bytes from the host and holds a bus request until the engine completes it.
// control_out is valid one cycle after the final byte; host_busy drops bytes while a cycle or unread data is pending.
module host_cmd_sequencer
  import host_cmd_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        host_data,
  input  logic              host_wr,
  input  logic              host_rd,
  input  logic              host_clr,
  output logic              host_busy,
  output logic [7:0]        host_rdata,
  output logic              host_rvalid,
  output logic              host_err,
  output logic [7:0]        control_out,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              data_read,
  input  logic              control_reset
);

  state_t     state, state_d;
  logic       cmd_read;
  logic       in_wait, accept, drop;
  logic       start, finish, abort, bad_cmd, expire;
  logic [7:0] ctrl_word;

  assign in_wait   = (state == S_WAIT);
  assign host_busy = in_wait | ((state == S_CMD) & host_rvalid);
  // host_clr beats a simultaneous byte: it is neither accepted nor flagged
  assign accept    = host_wr & ~host_busy & ~host_clr;
  assign drop      = host_wr & host_busy & ~host_clr;

  cmd_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (~in_wait | finish),
    .enable (in_wait),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_CMD;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    start   = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    bad_cmd = 1'b0;
    case (state)
      S_CMD: begin
        if (accept) begin
          if (host_data == CMD_READ || host_data == CMD_WRITE) state_d = S_ADDR_LO;
          else bad_cmd = 1'b1;
        end
      end
      S_ADDR_LO: begin
        if (host_clr)    state_d = S_CMD;
        else if (accept) state_d = S_ADDR_HI;
      end
      S_ADDR_HI: begin
        if (host_clr) begin
          state_d = S_CMD;
        end else if (accept) begin
          state_d = cmd_read ? S_WAIT : S_DATA;
          start   = cmd_read;
        end
      end
      S_DATA: begin
        if (host_clr) begin
          state_d = S_CMD;
        end else if (accept) begin
          state_d = S_WAIT;
          start   = 1'b1;
        end
      end
      S_WAIT: begin
        // completion wins over a watchdog expiry landing on the same cycle
        if (!control_reset) begin
          state_d = S_CMD;
          finish  = 1'b1;
        end else if (expire) begin
          state_d = S_CMD;
          abort   = 1'b1;
        end
      end
      default: state_d = S_CMD;
    endcase
  end

  always_comb begin
    ctrl_word              = 8'h00;
    ctrl_word[CTRL_RD_BIT] = cmd_read;
    ctrl_word[CTRL_WR_BIT] = ~cmd_read;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_read    <= 1'b0;
      control_out <= 8'h00;
      bus_addr    <= '0;
      bus_wdata   <= 8'h00;
      host_rdata  <= 8'h00;
      host_rvalid <= 1'b0;
      host_err    <= 1'b0;
    end else begin
      if (state == S_CMD && accept)     cmd_read <= (host_data == CMD_READ);
      if (state == S_ADDR_LO && accept) bus_addr[7:0] <= host_data;
      if (state == S_ADDR_HI && accept) bus_addr[ADDR_W-1:8] <= host_data[ADDR_W-9:0];
      if (state == S_DATA && accept)    bus_wdata <= host_data;

      if (start)                control_out <= ctrl_word;
      else if (finish || abort) control_out <= 8'h00;

      if (in_wait && cmd_read && !data_read) host_rdata <= bus_rdata;

      if (finish && cmd_read) host_rvalid <= 1'b1;
      else if (host_rd)       host_rvalid <= 1'b0;

      if (host_clr)                       host_err <= 1'b0;
      else if (bad_cmd || drop || abort)  host_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_host_cmd_sequencer.sv
// Directed bench: requests and read results go through a scoreboard; status flags are checked inline.
module tb_host_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  host_data;
  logic        host_wr, host_rd, host_clr;
  logic        host_busy;
  logic [7:0]  host_rdata;
  logic        host_rvalid, host_err;
  logic [7:0]  control_out;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        data_read, control_reset;

  int checks   = 0;
  int failures = 0;

  logic [31:0] req_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  prev_ctrl = 8'h00;
  logic        prev_rv   = 1'b0;

  always #5 clk = ~clk;

  host_cmd_sequencer #(.ADDR_W(16), .TIMEOUT(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .host_data     (host_data),
    .host_wr       (host_wr),
    .host_rd       (host_rd),
    .host_clr      (host_clr),
    .host_busy     (host_busy),
    .host_rdata    (host_rdata),
    .host_rvalid   (host_rvalid),
    .host_err      (host_err),
    .control_out   (control_out),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .data_read     (data_read),
    .control_reset (control_reset)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: a new bus request or a new read result pops the oldest expectation.
  always @(negedge clk) begin : monitor
    logic [31:0] e_req;
    logic [7:0]  e_rd;
    if (reset) begin
      if (control_out != 8'h00 && prev_ctrl == 8'h00) begin
        if (req_q.size() == 0) begin
          check("sb_unexpected_req", {bus_addr, bus_wdata, control_out}, 32'h0);
        end else begin
          e_req = req_q.pop_front();
          check("sb_req", {bus_addr, bus_wdata, control_out}, e_req);
        end
      end
      if (host_rvalid && !prev_rv) begin
        if (rd_q.size() == 0) begin
          check("sb_unexpected_rdata", {24'h0, host_rdata}, 32'hFFFF_FFFF);
        end else begin
          e_rd = rd_q.pop_front();
          check("sb_rdata", {24'h0, host_rdata}, {24'h0, e_rd});
        end
      end
    end
    prev_ctrl = control_out;
    prev_rv   = host_rvalid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    host_data = b;
    host_wr   = 1'b1;
    step();
    host_wr   = 1'b0;
  endtask

  task automatic pulse_creset();
    control_reset = 1'b0;
    step();
    control_reset = 1'b1;
  endtask

  task automatic clr();
    host_clr = 1'b1;
    step();
    host_clr = 1'b0;
  endtask

  task automatic rd();
    host_rd = 1'b1;
    step();
    host_rd = 1'b0;
  endtask

  task automatic push_req(input logic [15:0] a, input logic [7:0] d, input logic [7:0] c);
    req_q.push_back({a, d, c});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; host_data = 8'h00; host_wr = 1'b0; host_rd = 1'b0; host_clr = 1'b0;
    bus_rdata = 8'h00; data_read = 1'b1; control_reset = 1'b1;
    repeat (3) step();
    check("rst_ctrl",   control_out, 32'h0);
    check("rst_busy",   host_busy,   32'h0);
    check("rst_err",    host_err,    32'h0);
    check("rst_rvalid", host_rvalid, 32'h0);
    check("rst_addr",   bus_addr,    32'h0);
    check("rst_rdata",  host_rdata,  32'h0);
    reset = 1'b1;
    step();

    // 1: write
    push_req(16'h0220, 8'h5A, 8'h02);
    wr(8'h02); wr(8'h20); wr(8'h02); wr(8'h5A);
    check("t1_ctrl", control_out, 32'h02);
    check("t1_busy", host_busy,   32'h1);
    pulse_creset();
    check("t1_ctrl_done", control_out, 32'h0);
    check("t1_busy_done", host_busy,   32'h0);

    // 2: read with capture, drop while result pending, drain
    push_req(16'h022A, 8'h5A, 8'h01);
    rd_q.push_back(8'hC3);
    wr(8'h01); wr(8'h2A); wr(8'h02);
    bus_rdata = 8'hC3; data_read = 1'b0;
    step();
    data_read = 1'b1; bus_rdata = 8'h3C;
    step();
    pulse_creset();
    check("t2_rvalid", host_rvalid, 32'h1);
    check("t2_rdata",  host_rdata,  32'hC3);
    check("t2_busy",   host_busy,   32'h1);
    check("t2_ctrl",   control_out, 32'h0);
    wr(8'h01);
    check("t2_drop_err",    host_err,    32'h1);
    check("t2_drop_ctrl",   control_out, 32'h0);
    check("t2_drop_rvalid", host_rvalid, 32'h1);
    rd();
    check("t2_rd_rvalid", host_rvalid, 32'h0);
    check("t2_rd_busy",   host_busy,   32'h0);
    check("t2_rd_rdata",  host_rdata,  32'hC3);

    // 3: illegal command, clear, then a normal write
    clr();
    check("t3_clr_err0", host_err, 32'h0);
    wr(8'h03);
    check("t3_bad_err",  host_err,    32'h1);
    check("t3_bad_ctrl", control_out, 32'h0);
    check("t3_bad_busy", host_busy,   32'h0);
    clr();
    check("t3_clr_err1", host_err, 32'h0);
    push_req(16'h0310, 8'h77, 8'h02);
    wr(8'h02); wr(8'h10); wr(8'h03); wr(8'h77);
    check("t3_ctrl", control_out, 32'h02);
    pulse_creset();
    check("t3_ctrl_done", control_out, 32'h0);
    check("t3_err_done",  host_err,    32'h0);

    // 4: timeout after exactly 8 cycles in S_WAIT
    push_req(16'h0100, 8'hA5, 8'h02);
    wr(8'h02); wr(8'h00); wr(8'h01); wr(8'hA5);
    repeat (7) step();
    check("t4_ctrl_held", control_out, 32'h02);
    check("t4_err_held",  host_err,    32'h0);
    check("t4_busy_held", host_busy,   32'h1);
    step();
    check("t4_ctrl_to",   control_out, 32'h0);
    check("t4_err_to",    host_err,    32'h1);
    check("t4_busy_to",   host_busy,   32'h0);
    check("t4_rvalid_to", host_rvalid, 32'h0);

    // 5: abort mid-command, clr+wr collision, clr in S_WAIT, async reset in S_WAIT
    wr(8'h02); wr(8'h44);
    clr();
    check("t5_clr_err", host_err, 32'h0);
    host_clr = 1'b1; host_wr = 1'b1; host_data = 8'h01;
    step();
    host_clr = 1'b0; host_wr = 1'b0;
    check("t5_coll_err",  host_err,  32'h0);
    check("t5_coll_busy", host_busy, 32'h0);
    push_req(16'h0155, 8'hA5, 8'h01);
    wr(8'h01); wr(8'h55); wr(8'h01);
    check("t5_ctrl", control_out, 32'h01);
    clr();
    check("t5_wait_clr_ctrl", control_out, 32'h01);
    check("t5_wait_clr_busy", host_busy,   32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_arst_ctrl",  control_out, 32'h0);
    check("t5_arst_busy",  host_busy,   32'h0);
    check("t5_arst_addr",  bus_addr,    32'h0);
    check("t5_arst_wdata", bus_wdata,   32'h0);
    check("t5_arst_rdata", host_rdata,  32'h0);
    step();
    reset = 1'b1;
    step();

    // 6: data_read during a write is ignored
    push_req(16'h1234, 8'h9E, 8'h02);
    wr(8'h02); wr(8'h34); wr(8'h12); wr(8'h9E);
    bus_rdata = 8'hFF; data_read = 1'b0;
    step();
    data_read = 1'b1;
    pulse_creset();
    step();
    check("t6_rvalid", host_rvalid, 32'h0);
    check("t6_rdata",  host_rdata,  32'h0);
    check("t6_ctrl",   control_out, 32'h0);

    step();
    check("sb_req_drained", 32'(req_q.size()), 32'h0);
    check("sb_rd_drained",  32'(rd_q.size()),  32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
